// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock, then releases the peripheral reset
// ahead of the CPU reset in ordered stages. The sequence restarts on lock
// loss or on a software reset request. All outputs come straight from
// registers, so downstream reset trees see glitch-free levels.
module reset_sequencer #(
    parameter int LOCK_CYCLES   = 16,
    parameter int STAGE_CYCLES  = 4,
    parameter int SW_RST_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       periph_resetn,
    output logic       cpu_resetn,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STAGE     = 2'd1,
        RUN       = 2'd2,
        SW_HOLD   = 2'd3
    } state_t;

    // Terminal counts: the N-th qualifying edge is the one that sees cnt = N-1.
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST    = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             periph_reg, periph_next;
    logic             cpu_reg, cpu_next;
    logic             ready_reg, ready_next;
    logic             ack_reg, ack_next;
    logic [7:0]       llc_reg, llc_next;
    logic             lock_loss;

    // Lock loss only matters once the sequence has left WAIT_LOCK; inside
    // WAIT_LOCK a low sample just restarts qualification.
    assign lock_loss = !pll_locked && (state_reg != WAIT_LOCK);

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= WAIT_LOCK;
            cnt_reg    <= '0;
            periph_reg <= 1'b0;
            cpu_reg    <= 1'b0;
            ready_reg  <= 1'b0;
            ack_reg    <= 1'b0;
            llc_reg    <= 8'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            periph_reg <= periph_next;
            cpu_reg    <= cpu_next;
            ready_reg  <= ready_next;
            ack_reg    <= ack_next;
            llc_reg    <= llc_next;
        end
    end

    // Next-state and next-output logic; lock loss outranks the software request.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        periph_next = periph_reg;
        cpu_next    = cpu_reg;
        ready_next  = ready_reg;
        ack_next    = 1'b0;
        llc_next    = llc_reg;

        if (lock_loss) begin
            // Both resets assert together on the same edge.
            state_next  = WAIT_LOCK;
            cnt_next    = '0;
            periph_next = 1'b0;
            cpu_next    = 1'b0;
            ready_next  = 1'b0;
            if (llc_reg != 8'hFF) begin
                llc_next = llc_reg + 8'd1;
            end
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    periph_next = 1'b0;
                    cpu_next    = 1'b0;
                    ready_next  = 1'b0;
                    if (!pll_locked) begin
                        cnt_next = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next  = STAGE;
                        cnt_next    = '0;
                        periph_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                STAGE: begin
                    if (cnt_reg == STAGE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                        cpu_next   = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        state_next  = SW_HOLD;
                        cnt_next    = '0;
                        periph_next = 1'b0;
                        cpu_next    = 1'b0;
                        ready_next  = 1'b0;
                        ack_next    = 1'b1;
                    end
                end
                SW_HOLD: begin
                    if (cnt_reg == SW_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next  = WAIT_LOCK;
                    cnt_next    = '0;
                    periph_next = 1'b0;
                    cpu_next    = 1'b0;
                    ready_next  = 1'b0;
                end
            endcase
        end
    end

    assign sw_rst_ack    = ack_reg;
    assign periph_resetn = periph_reg;
    assign cpu_resetn    = cpu_reg;
    assign ready         = ready_reg;
    assign lock_loss_cnt = llc_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vectors with hand-computed edge counts for
// the default parameters (16 lock / 4 stage / 8 software-hold cycles).
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int n_cmp;
    int n_bad;

    reset_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .sw_rst_req    (sw_rst_req),
        .sw_rst_ack    (sw_rst_ack),
        .periph_resetn (periph_resetn),
        .cpu_resetn    (cpu_resetn),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled on negedges.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The CPU must never be out of reset while peripherals are held.
    always @(negedge clk) begin
        if (cpu_resetn && !periph_resetn) begin
            check_val("order_invariant", 32'(cpu_resetn), 32'(periph_resetn));
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
        step(3);

        // Reset state
        check_val("rst_periph", 32'(periph_resetn), 32'd0);
        check_val("rst_cpu",    32'(cpu_resetn),    32'd0);
        check_val("rst_ready",  32'(ready),         32'd0);
        check_val("rst_ack",    32'(sw_rst_ack),    32'd0);
        check_val("rst_llc",    32'(lock_loss_cnt), 32'd0);

        // Clean power-up: periph after edge 16, cpu/ready after edge 20
        reset = 1'b0;
        step(15);
        check_val("pu_periph_e15", 32'(periph_resetn), 32'd0);
        step(1);
        check_val("pu_periph_e16", 32'(periph_resetn), 32'd1);
        check_val("pu_cpu_e16",    32'(cpu_resetn),    32'd0);
        step(3);
        check_val("pu_cpu_e19",    32'(cpu_resetn),    32'd0);
        step(1);
        check_val("pu_cpu_e20",    32'(cpu_resetn),    32'd1);
        check_val("pu_ready_e20",  32'(ready),         32'd1);
        check_val("pu_llc",        32'(lock_loss_cnt), 32'd0);

        // One-cycle lock drop in RUN, then full re-sequence
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        check_val("ll_periph", 32'(periph_resetn), 32'd0);
        check_val("ll_cpu",    32'(cpu_resetn),    32'd0);
        check_val("ll_ready",  32'(ready),         32'd0);
        check_val("ll_llc",    32'(lock_loss_cnt), 32'd1);
        step(15);
        check_val("ll_periph_e15", 32'(periph_resetn), 32'd0);
        step(1);
        check_val("ll_periph_e16", 32'(periph_resetn), 32'd1);
        step(4);
        check_val("ll_cpu_e20",    32'(cpu_resetn),    32'd1);

        // Software reset: ack one cycle, 8-cycle hold, then 16 + 4
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check_val("sw_ack",      32'(sw_rst_ack),    32'd1);
        check_val("sw_periph",   32'(periph_resetn), 32'd0);
        check_val("sw_ready",    32'(ready),         32'd0);
        step(1);
        check_val("sw_ack_drop", 32'(sw_rst_ack),    32'd0);
        step(7);
        check_val("sw_hold_e8",  32'(periph_resetn), 32'd0);
        step(15);
        check_val("sw_periph_e23", 32'(periph_resetn), 32'd0);
        step(1);
        check_val("sw_periph_e24", 32'(periph_resetn), 32'd1);
        check_val("sw_cpu_e24",    32'(cpu_resetn),    32'd0);
        step(4);
        check_val("sw_cpu_e28",    32'(cpu_resetn),    32'd1);
        check_val("sw_llc",        32'(lock_loss_cnt), 32'd1);

        // Simultaneous request and lock loss: lock-loss path, no ack
        sw_rst_req = 1'b1;
        pll_locked = 1'b0;
        step(1);
        sw_rst_req = 1'b0;
        pll_locked = 1'b1;
        check_val("both_ack",    32'(sw_rst_ack),    32'd0);
        check_val("both_llc",    32'(lock_loss_cnt), 32'd2);
        check_val("both_periph", 32'(periph_resetn), 32'd0);

        // Request during STAGE is ignored
        step(16);
        check_val("stg_periph", 32'(periph_resetn), 32'd1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check_val("stg_ack",  32'(sw_rst_ack), 32'd0);
        check_val("stg_cpu",  32'(cpu_resetn), 32'd0);
        step(3);
        check_val("stg_cpu_run", 32'(cpu_resetn), 32'd1);
        check_val("stg_ack2",    32'(sw_rst_ack), 32'd0);

        // Reset asserted mid-STAGE
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        check_val("mid_llc3", 32'(lock_loss_cnt), 32'd3);
        step(18);
        check_val("mid_in_stage", 32'(periph_resetn), 32'd1);
        reset = 1'b1;
        step(1);
        check_val("mid_periph", 32'(periph_resetn), 32'd0);
        check_val("mid_cpu",    32'(cpu_resetn),    32'd0);
        check_val("mid_ready",  32'(ready),         32'd0);
        check_val("mid_llc",    32'(lock_loss_cnt), 32'd0);

        // Lock glitch at edge 10 restarts qualification: periph 26, cpu 30
        reset = 1'b0;
        step(9);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(15);
        check_val("gl_periph_e25", 32'(periph_resetn), 32'd0);
        step(1);
        check_val("gl_periph_e26", 32'(periph_resetn), 32'd1);
        step(3);
        check_val("gl_cpu_e29",    32'(cpu_resetn),    32'd0);
        step(1);
        check_val("gl_cpu_e30",    32'(cpu_resetn),    32'd1);

        // 300 lock losses: counter saturates at 255
        pll_locked = 1'b0;
        step(1);
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b1;
            step(16);
            pll_locked = 1'b0;
            step(1);
            if (i == 254) check_val("sat_254", 32'(lock_loss_cnt), 32'd254);
            if (i == 255) check_val("sat_255", 32'(lock_loss_cnt), 32'd255);
            if (i == 256) check_val("sat_256", 32'(lock_loss_cnt), 32'd255);
        end
        check_val("sat_300", 32'(lock_loss_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
